mult32_seq: RTL and testbench

- Sequential shift-add 32x32 multiplier sitting directly upstream of the ALU result mux.
- Multiplies the same A/B operand buses the bitwise units consume.
- Delivers a 64-bit product (Y_lo for the 32-bit ALU result, Y_hi for the HI register) after a fixed WIDTH-cycle run.
- Start/busy/done handshake lets the multi-cycle control unit stall on it.

---
 rtl/mult32_seq.sv | 158 +++++++++++++++
 tb/tb_mult32_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - sequential shift-add WIDTHxWIDTH multiplier with start/busy/done handshake
//
// Purpose:
//   Multiplies A by B with one shift-add iteration per clock and a fixed
//   WIDTH-cycle run. The 2*WIDTH-bit product appears on Y_hi/Y_lo together
//   with a one-cycle done pulse and holds there until the next completion
//   or reset.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   A      in   WIDTH  multiplicand
//   B      in   WIDTH  multiplier
//   busy   out  1      high while an operation is running
//   done   out  1      one-cycle pulse when Y_hi/Y_lo update
//   Y_lo   out  WIDTH  product bits [WIDTH-1:0]
//   Y_hi   out  WIDTH  product bits [2*WIDTH-1:WIDTH]
//
// Build option:
//   MULT32_SIGNED_EN  when defined, A/B are two's complement; magnitudes are
//                     multiplied and the product is negated at the final edge.

module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_lo,
  output logic [WIDTH-1:0] Y_hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH:0]     r_p;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_y_lo;
  logic [WIDTH-1:0]     r_y_hi;

  logic                 w_last;
  logic [WIDTH:0]       w_upper;
  logic [2*WIDTH-1:0]   w_product;
  logic [2*WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;

  // Final iteration is the one that brings the counter from WIDTH-1 to WIDTH.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Conditional add into the upper half; the carry lands in P[2*WIDTH].
  assign w_upper = r_p[0] ? ({1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                          : r_p[2*WIDTH:WIDTH];

  // Low 2*WIDTH bits of P after the add and the right shift; the shifted-in
  // top bit is always 0 and is re-attached when P is written back.
  assign w_product = {w_upper, r_p[WIDTH-1:1]};

`ifdef MULT32_SIGNED_EN
  logic r_neg;

  // Magnitudes as unsigned; the most negative value maps to 2^(WIDTH-1).
  assign w_mag_a  = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
  assign w_mag_b  = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
  assign w_result = r_neg ? ((2*WIDTH)'(0) - w_product) : w_product;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg <= A[WIDTH-1] ^ B[WIDTH-1];
    end
  end
`else
  assign w_mag_a  = A;
  assign w_mag_b  = B;
  assign w_result = w_product;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, shift-add iterations, result load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_y_lo  <= '0;
      r_y_hi  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_mag_a;
            r_p     <= {1'b0, {WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_p   <= {1'b0, w_product};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y_hi <= w_result[2*WIDTH-1:WIDTH];
            r_y_lo <= w_result[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Y_lo = r_y_lo;
  assign Y_hi = r_y_hi;

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - scoreboard testbench for mult32_seq

module tb_mult32_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Y_lo;
  logic [W-1:0] Y_hi;

  int n_checks = 0;
  int n_pass   = 0;

  mult32_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y_lo  (Y_lo),
    .Y_hi  (Y_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT32_SIGNED_EN
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Reference timing model and scoreboard
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  int          m_cnt   = 0;
  logic [63:0] m_y     = '0;
  logic [63:0] sb_q[$];
  bit          mon_en  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      m_y     = '0;
      sb_q.delete();
    end else begin
      case (m_state)
        M_IDLE: if (start) begin
          sb_q.push_back(ref_product(A, B));
          m_cnt   = 0;
          m_state = M_RUN;
        end
        M_RUN: begin
          m_cnt++;
          if (m_cnt == W) begin
            if (sb_q.size() > 0) m_y = sb_q.pop_front();
            m_state = M_DONE;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", 64'(busy), 64'(m_state == M_RUN));
      check("mon_done", 64'(done), 64'(m_state == M_DONE));
      check("mon_y", {Y_hi, Y_lo}, m_y);
    end
  end

  // One operation: accept, count busy cycles, wait (bounded) for done.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] exp, input bit chk_hold, input logic [63:0] hold_val);
    int busy_cycles;
    bit got;
    busy_cycles = 0;
    got = 1'b0;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        if (chk_hold) check({tag, "_hold"}, {Y_hi, Y_lo}, hold_val);
      end
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd32);
    check({tag, "_y"}, {Y_hi, Y_lo}, exp);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_y", {Y_hi, Y_lo}, 64'd0);
    rst_n = 1'b1;

    do_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 64'd0);
`ifdef MULT32_SIGNED_EN
    do_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'd0);
`else
    do_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 64'd0);
`endif
    do_op("zero", 32'd0, 32'h1234_5678, 64'd0, 1'b0, 64'd0);

    // start held high with operands changing every cycle
    @(posedge clk); #1;
    A = $urandom; B = $urandom; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 102; i++) begin
      @(posedge clk); #1;
      A = $urandom; B = $urandom;
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("held_done_count", 64'(dones), 64'd3);

    // reset in the middle of a run
    @(posedge clk); #1;
    A = 32'd9; B = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_y", {Y_hi, Y_lo}, 64'd0);
    do_op("7x6", 32'd7, 32'd6, 64'd42, 1'b0, 64'd0);

    // previous result must hold through the whole run
    do_op("2x3", 32'd2, 32'd3, 64'd6, 1'b0, 64'd0);
    do_op("10x10", 32'd10, 32'd10, 64'd100, 1'b1, 64'd6);

`ifdef MULT32_SIGNED_EN
    do_op("m3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 64'd0);
`else
    do_op("fdx5", 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 1'b0, 64'd0);
`endif
    do_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'd0);

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
